outstream: RTL and testbench
============================

Name: outstream

Overview:
- Output-collection stage behind the systolic array.
- Samples the per-cycle array output vector `result_in`, de-skews it according to dataflow, and assembles the complete M×N result matrix in `result_out`, row-major.
- Supports weight-stationary (WS: diagonal-skewed column outputs) and output-stationary (OS: whole rows drained bottom row first).
- Raises `outstream_done` once the matrix is complete.

Parameters:
- SYS_ARR_SIZE, 8, array dimension; max M, N, K.
- ACT_WIDTH, 8, activation width; interface only.
- WGT_WIDTH, 8, weight width; interface only.
- MULT_OUT_WIDTH, ACT_WIDTH+WGT_WIDTH, multiplier width; interface only.
- PE_OUT_WIDTH, 32, width of one result element.
- OP_SIG_WIDTH, 3, operation signal width.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `M`  input  $clog2(SYS_ARR_SIZE)+1  result rows, 1..SYS_ARR_SIZE.
- `N`  input  $clog2(SYS_ARR_SIZE)+1  result columns, 1..SYS_ARR_SIZE.
- `K`  input  $clog2(SYS_ARR_SIZE)+1  reduction depth, 1..SYS_ARR_SIZE.
- `operation_signal_in`  input  OP_SIG_WIDTH  operation code.
- `result_in`  input  PE_OUT_WIDTH*SYS_ARR_SIZE  lane j = bits [j*PE_OUT_WIDTH +: PE_OUT_WIDTH].
- `result_out`  output  SYS_ARR_SIZE*SYS_ARR_SIZE*PE_OUT_WIDTH  slot s = bits [s*PE_OUT_WIDTH +: PE_OUT_WIDTH]; element (i,j) lives in slot i*N+j.
- `outstream_done`  output  1  matrix complete.

Behaviour:
- Reset (`reset`=0, async): all `result_out` slots 0, `outstream_done`=0, run counter c=0, state IDLE.
- Opcodes, sampled on rising edge:
  - 3'b001 WS_LOAD: state←WS, c←0, done←0, latch M/N/K.
  - 3'b000 WS_RUN: advances c only in state WS.
  - 3'b100 OS_LOAD: state←OS, c←0, done←0, latch M/N/K.
  - 3'b110 OS_RUN: advances c only in state OS.
  - Any other code, or a RUN code in the wrong state: hold everything.
- On each RUN edge c←c+1. The captures below use the new value of c; the first RUN edge gives c=1.
- Counter sizing: counter ≥ $clog2(4*SYS_ARR_SIZE)+1 bits; saturates once done=1.
- WS capture:
  - Diagonal d = c−(SYS_ARR_SIZE+1), valid for 0 ≤ d ≤ M+N−2.
  - For each lane j < N: i = d−j; if 0 ≤ i < M, slot i*N+j ← lane j.
  - Lanes j ≥ N and out-of-range i are ignored.
- OS capture:
  - Index r = c−(K+2), valid for 0 ≤ r ≤ M−1.
  - For j < N: slot (M−1−r)*N+j ← lane j (bottom row arrives first).
- Capture is registered: data sampled on edge e is visible on `result_out` after e.
- `outstream_done` is set on the same edge as the final capture (WS d=M+N−2; OS r=M−1).
- `outstream_done` stays 1, with `result_out` frozen, until the next LOAD or reset. Later RUN cycles change nothing.
- Slots never written (slot ≥ M*N) remain 0.
- Reset mid-operation: immediate clear, back to IDLE.
- LOAD issued mid-operation: restarts the counter. Slot contents follow the optional feature below.

Optional Feature:
- Macro: OUTSTREAM_CLEAR_ON_LOAD_EN.
- Defined: WS_LOAD and OS_LOAD also clear every `result_out` slot to 0.
- Undefined: LOAD leaves previous slot contents; only reset zeroes them; slots are overwritten as captured.

Test Plan:
- Common setup: M=3, N=5, K=4, SYS_ARR_SIZE=8, PE_OUT_WIDTH=32.
- Filler: all non-listed lanes carry 666.
- WS, full sequence:
  - Stimulus: reset, WS_LOAD, then WS_RUN. Run cycles 1–8 carry 666 in all lanes. Cycles 9–15 carry diagonals d0..d6, lanes listed from lane 0:
    - d0: 49
    - d1: 71, 72
    - d2: 115, 99, 43
    - d3: x, 89, 92, 53
    - d4: x, x, 80, 89, 33
    - d5: x, x, x, 96, 79
    - d6: x, x, x, x, 85
  - Response: slots 0..14 = 49, 72, 43, 53, 33, 71, 99, 92, 89, 79, 115, 89, 80, 96, 85; all other slots 0.
  - `outstream_done`=1 right after the cycle-15 edge.
- WS, partial result: after d0, only slot0=49 and all other slots 0. After d1: slots 0,1,5 = 49, 72, 71.
- WS, hold: two further WS_RUN cycles with 666 → `result_out` and done unchanged.
- OS, full sequence:
  - Stimulus: reset, OS_LOAD, then OS_RUN. Run cycles 1–5 carry 666. Cycles 6, 7, 8 carry lanes 0–4 as follows:
    - cycle 6: 115, 89, 80, 96, 85
    - cycle 7: 71, 99, 92, 89, 79
    - cycle 8: 49, 72, 43, 53, 33
  - Response after cycle 6: slots 10–14 filled, slots 0–9 still 0.
  - Response after cycle 8: same matrix as WS, with done=1.
- Reset mid-WS at run cycle 12 → all slots 0 and done=0 immediately; further WS_RUN is ignored until a LOAD.
- Unknown opcode 3'b111 during a WS run → counter frozen; capture resumes on the next WS_RUN.

Source files
------------

// File: rtl/outstream.sv
// outstream: de-skews systolic array outputs (WS diagonals / OS rows) into a row-major M x N result matrix.
// Optional macro OUTSTREAM_CLEAR_ON_LOAD_EN: WS_LOAD/OS_LOAD also zero every result slot.
module outstream #(
    parameter int SYS_ARR_SIZE   = 8,
    parameter int ACT_WIDTH      = 8,
    parameter int WGT_WIDTH      = 8,
    parameter int MULT_OUT_WIDTH = ACT_WIDTH + WGT_WIDTH,
    parameter int PE_OUT_WIDTH   = 32,
    parameter int OP_SIG_WIDTH   = 3
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [$clog2(SYS_ARR_SIZE):0]                M,
    input  logic [$clog2(SYS_ARR_SIZE):0]                N,
    input  logic [$clog2(SYS_ARR_SIZE):0]                K,
    input  logic [OP_SIG_WIDTH-1:0]                      operation_signal_in,
    input  logic [PE_OUT_WIDTH*SYS_ARR_SIZE-1:0]         result_in,
    output logic [SYS_ARR_SIZE*SYS_ARR_SIZE*PE_OUT_WIDTH-1:0] result_out,
    output logic                                         outstream_done
);
    localparam int DW = $clog2(SYS_ARR_SIZE) + 1;
    localparam int CW = $clog2(4 * SYS_ARR_SIZE) + 1;
    localparam int SLOTS = SYS_ARR_SIZE * SYS_ARR_SIZE;
    localparam int SW = $clog2(SLOTS);
    localparam logic [OP_SIG_WIDTH-1:0] OP_WS_RUN  = 'b000;
    localparam logic [OP_SIG_WIDTH-1:0] OP_WS_LOAD = 'b001;
    localparam logic [OP_SIG_WIDTH-1:0] OP_OS_LOAD = 'b100;
    localparam logic [OP_SIG_WIDTH-1:0] OP_OS_RUN  = 'b110;

    if (PE_OUT_WIDTH < MULT_OUT_WIDTH) begin : g_width_check
        $error("outstream: PE_OUT_WIDTH narrower than multiplier output");
    end

    typedef enum logic [1:0] {S_IDLE, S_WS, S_OS} state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [DW-1:0]           r_m, r_n, r_k;
    logic                    r_done;
    logic [PE_OUT_WIDTH-1:0] r_res [SLOTS];

    logic [PE_OUT_WIDTH-1:0] w_lane [SYS_ARR_SIZE];
    logic [PE_OUT_WIDTH-1:0] w_res_nxt [SLOTS];
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_load, w_run, w_ws_hit, w_os_hit, w_last;
    int                      w_d, w_r;

    for (genvar g = 0; g < SYS_ARR_SIZE; g++) begin : g_lane
        assign w_lane[g] = result_in[g*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    end
    for (genvar g = 0; g < SLOTS; g++) begin : g_out
        assign result_out[g*PE_OUT_WIDTH +: PE_OUT_WIDTH] = r_res[g];
    end
    assign outstream_done = r_done;

    assign w_load = operation_signal_in == OP_WS_LOAD || operation_signal_in == OP_OS_LOAD;
    // A finished matrix freezes the counter and slots until the next LOAD.
    assign w_run = !r_done && ((operation_signal_in == OP_WS_RUN && r_state == S_WS) ||
                               (operation_signal_in == OP_OS_RUN && r_state == S_OS));
    assign w_cnt_nxt = r_cnt + CW'(1);

    always_comb begin
        w_res_nxt = r_res;
        w_d = int'(w_cnt_nxt) - (SYS_ARR_SIZE + 1);
        w_r = int'(w_cnt_nxt) - (int'(r_k) + 2);
        w_ws_hit = r_state == S_WS && w_d >= 0 && w_d <= int'(r_m) + int'(r_n) - 2;
        w_os_hit = r_state == S_OS && w_r >= 0 && w_r < int'(r_m);
        w_last = (w_ws_hit && w_d == int'(r_m) + int'(r_n) - 2) || (w_os_hit && w_r == int'(r_m) - 1);
        for (int j = 0; j < SYS_ARR_SIZE; j++) begin
            if (w_ws_hit && j < int'(r_n) && w_d - j >= 0 && w_d - j < int'(r_m))
                w_res_nxt[SW'((w_d - j) * int'(r_n) + j)] = w_lane[j];
            if (w_os_hit && j < int'(r_n))
                w_res_nxt[SW'((int'(r_m) - 1 - w_r) * int'(r_n) + j)] = w_lane[j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_m     <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_res   <= '{default: '0};
        end else if (w_load) begin
            r_state <= operation_signal_in == OP_WS_LOAD ? S_WS : S_OS;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_m     <= M;
            r_n     <= N;
            r_k     <= K;
`ifdef OUTSTREAM_CLEAR_ON_LOAD_EN
            r_res   <= '{default: '0};
`else
            r_res   <= r_res;
`endif
        end else if (w_run) begin
            r_cnt  <= w_cnt_nxt;
            r_done <= w_last;
            r_res  <= w_res_nxt;
        end
    end
endmodule

// File: tb/tb_outstream.sv
// tb_outstream: directed WS/OS collection vectors with hand-computed result matrices.
module tb_outstream;
    localparam int S = 8;
    localparam int W = 32;
    localparam int DW = $clog2(S) + 1;
    localparam int X = 666;
    localparam logic [2:0] WS_RUN = 3'b000, WS_LOAD = 3'b001, OS_LOAD = 3'b100, OS_RUN = 3'b110, NOP = 3'b111;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DW-1:0]     M = DW'(3), N = DW'(5), K = DW'(4);
    logic [2:0]        op = NOP;
    logic [S*W-1:0]    result_in;
    logic [S*S*W-1:0]  result_out;
    logic              outstream_done;
    int                vectors = 0;
    int                miscompares = 0;
    int                exp_m [S*S];

    outstream dut (
        .clk(clk), .reset(reset), .M(M), .N(N), .K(K),
        .operation_signal_in(op), .result_in(result_in),
        .result_out(result_out), .outstream_done(outstream_done)
    );

    always #5 clk = ~clk;

    function automatic logic [S*W-1:0] mk(input int a0, input int a1, input int a2, input int a3, input int a4);
        logic [S*W-1:0] v;
        v = {S{32'd666}};
        v[0*W +: W] = 32'(a0);
        v[1*W +: W] = 32'(a1);
        v[2*W +: W] = 32'(a2);
        v[3*W +: W] = 32'(a3);
        v[4*W +: W] = 32'(a4);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(input string tag);
        for (int s = 0; s < S*S; s++)
            chk($sformatf("%s slot%0d", tag, s), result_out[s*W +: W], 32'(exp_m[s]));
    endtask

    task automatic chk_done(input string tag, input logic e);
        chk(tag, {31'b0, outstream_done}, {31'b0, e});
    endtask

    task automatic step(input logic [2:0] o, input logic [S*W-1:0] v);
        op = o;
        result_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int s = 0; s < S*S; s++) exp_m[s] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        result_in = mk(X, X, X, X, X);
        clear_exp();
        repeat (2) @(posedge clk);
        #1;
        chk_mat("reset");
        chk_done("reset done", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        // WS full sequence, with a wrong-state OS_RUN and an unknown opcode mixed in
        step(WS_LOAD, mk(X, X, X, X, X));
        chk_done("ws load done", 1'b0);
        step(OS_RUN, mk(1, 2, 3, 4, 5));
        repeat (8) step(WS_RUN, mk(X, X, X, X, X));
        chk_mat("ws filler");
        step(WS_RUN, mk(49, X, X, X, X));
        exp_m[0] = 49;
        chk_mat("ws d0");
        step(WS_RUN, mk(71, 72, X, X, X));
        exp_m[5] = 71; exp_m[1] = 72;
        chk_mat("ws d1");
        step(NOP, mk(1, 2, 3, 4, 5));
        chk_mat("ws nop");
        step(WS_RUN, mk(115, 99, 43, X, X));
        exp_m[10] = 115; exp_m[6] = 99; exp_m[2] = 43;
        step(WS_RUN, mk(X, 89, 92, 53, X));
        exp_m[11] = 89; exp_m[7] = 92; exp_m[3] = 53;
        step(WS_RUN, mk(X, X, 80, 89, 33));
        exp_m[12] = 80; exp_m[8] = 89; exp_m[4] = 33;
        step(WS_RUN, mk(X, X, X, 96, 79));
        exp_m[13] = 96; exp_m[9] = 79;
        chk_done("ws d5 done", 1'b0);
        step(WS_RUN, mk(X, X, X, X, 85));
        exp_m[14] = 85;
        chk_mat("ws d6");
        chk_done("ws d6 done", 1'b1);
        repeat (2) step(WS_RUN, mk(X, X, X, X, X));
        chk_mat("ws hold");
        chk_done("ws hold done", 1'b1);
        // OS full sequence after an asynchronous reset pulse
        #2 reset = 1'b0;
        #1;
        clear_exp();
        chk_mat("reset pulse");
        chk_done("reset pulse done", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(OS_LOAD, mk(X, X, X, X, X));
        repeat (5) step(OS_RUN, mk(X, X, X, X, X));
        chk_mat("os filler");
        step(OS_RUN, mk(115, 89, 80, 96, 85));
        exp_m[10] = 115; exp_m[11] = 89; exp_m[12] = 80; exp_m[13] = 96; exp_m[14] = 85;
        chk_mat("os c6");
        chk_done("os c6 done", 1'b0);
        step(OS_RUN, mk(71, 99, 92, 89, 79));
        exp_m[5] = 71; exp_m[6] = 99; exp_m[7] = 92; exp_m[8] = 89; exp_m[9] = 79;
        chk_done("os c7 done", 1'b0);
        step(OS_RUN, mk(49, 72, 43, 53, 33));
        exp_m[0] = 49; exp_m[1] = 72; exp_m[2] = 43; exp_m[3] = 53; exp_m[4] = 33;
        chk_mat("os c8");
        chk_done("os c8 done", 1'b1);
        // Reload without reset, partial WS run, then reset mid-run at cycle 12
        step(WS_LOAD, mk(X, X, X, X, X));
`ifdef OUTSTREAM_CLEAR_ON_LOAD_EN
        clear_exp();
`endif
        chk_mat("ws reload");
        chk_done("ws reload done", 1'b0);
        repeat (8) step(WS_RUN, mk(X, X, X, X, X));
        step(WS_RUN, mk(1049, X, X, X, X));
        exp_m[0] = 1049;
        step(WS_RUN, mk(1071, 1072, X, X, X));
        exp_m[5] = 1071; exp_m[1] = 1072;
        step(WS_RUN, mk(1115, 1099, 1043, X, X));
        exp_m[10] = 1115; exp_m[6] = 1099; exp_m[2] = 1043;
        step(WS_RUN, mk(X, 1089, 1092, 1053, X));
        exp_m[11] = 1089; exp_m[7] = 1092; exp_m[3] = 1053;
        chk_mat("ws rerun c12");
        chk_done("ws rerun done", 1'b0);
        #2 reset = 1'b0;
        #1;
        clear_exp();
        chk_mat("mid reset");
        chk_done("mid reset done", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) step(WS_RUN, mk(49, 72, 43, 53, 33));
        chk_mat("idle ignore");
        chk_done("idle ignore done", 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
